// File: rtl/sequenciador_pkg.sv
// Shared definitions for the cube-move sequencer: FSM state codes,
// mov_codigo field positions and gripper command levels.
package sequenciador_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'b0000,
    CARREGA      = 4'b0001,
    FECHA_GARRA  = 4'b0010,
    ESPERA_FECHA = 4'b0011,
    GIRA         = 4'b0100,
    ESPERA_GIRO  = 4'b0101,
    CONTA_QUARTO = 4'b0110,
    ABRE_GARRA   = 4'b0111,
    ESPERA_ABRE  = 4'b1000,
    ERRO         = 4'b1111
  } estado_t;

  localparam logic [3:0] DB_ILEGAL = 4'b1110;

  localparam int BIT_SENTIDO = 2;
  localparam int QUARTOS_MSB = 1;
  localparam int QUARTOS_LSB = 0;

  localparam logic GARRA_FECHA = 1'b1;
  localparam logic GARRA_ABRE  = 1'b0;

  // States in which the watchdog counts cycles waiting for a pronto_*.
  function automatic logic em_espera(input estado_t e);
    return (e == ESPERA_FECHA) || (e == ESPERA_GIRO) || (e == ESPERA_ABRE);
  endfunction

endpackage

// File: rtl/fila_movimentos.sv
// Synchronous FIFO buffering accepted move codes; the head word is
// presented combinationally so the consumer can latch it while popping.
module fila_movimentos #(
  parameter int PROFUNDIDADE = 4,
  parameter int LARGURA      = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [LARGURA-1:0] dado_escrita,
  output logic [LARGURA-1:0] dado_leitura,
  output logic               cheia,
  output logic               vazia
);

  localparam int PW = $clog2(PROFUNDIDADE);
  localparam logic [PW:0] CONTAGEM_CHEIA = PROFUNDIDADE[PW:0];

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [PW-1:0]      ptr_escrita;
  logic [PW-1:0]      ptr_leitura;
  logic [PW:0]        contagem;
  logic               escreve;
  logic               le;

  assign escreve = push & ~cheia;
  assign le      = pop & ~vazia;

  // NOTE: storage has no reset; only pointers and count define validity,
  // so a flush is just clearing them.
  always_ff @(posedge clock) begin
    if (escreve) mem[ptr_escrita] <= dado_escrita;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_escrita <= '0;
      ptr_leitura <= '0;
      contagem    <= '0;
    end else begin
      if (escreve) ptr_escrita <= ptr_escrita + 1'b1;
      if (le)      ptr_leitura <= ptr_leitura + 1'b1;
      case ({escreve, le})
        2'b10:   contagem <= contagem + 1'b1;
        2'b01:   contagem <= contagem - 1'b1;
        default: contagem <= contagem;
      endcase
    end
  end

  assign cheia        = (contagem == CONTAGEM_CHEIA);
  assign vazia        = (contagem == '0);
  assign dado_leitura = mem[ptr_leitura];

endmodule

// File: rtl/sequenciador_movimentos.sv
// Move sequencer: queues cube moves and runs each as grip close, N quarter
// turns, grip open, with a watchdog on every wait for a servo unit.
module sequenciador_movimentos
  import sequenciador_pkg::*;
#(
  parameter int PROFUNDIDADE   = 4,
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mov_valido,
  input  logic [2:0] mov_codigo,
  output logic       mov_pronto,
  output logic       iniciar_servo,
  output logic       sentido,
  input  logic       pronto_servo,
  output logic       iniciar_garra,
  output logic       fecha,
  input  logic       pronto_garra,
  output logic       ocupado,
  output logic       fila_vazia,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int WD_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [WD_W-1:0] WD_LIMITE = WD_W'(TIMEOUT_CICLOS - 1);

  estado_t         estado;
  estado_t         estado_prox;
  logic [1:0]      quartos;
  logic [WD_W-1:0] wd;
  logic            wd_expirou;
  logic            fila_cheia;
  logic            push;
  logic            pop;
  logic [2:0]      dado_fila;

  assign mov_pronto = ~fila_cheia & ~erro;
  // Zero-turn codes complete the handshake but are never stored.
  assign push = mov_valido & mov_pronto & (|mov_codigo[QUARTOS_MSB:QUARTOS_LSB]);

  fila_movimentos #(
    .PROFUNDIDADE(PROFUNDIDADE),
    .LARGURA     (3)
  ) u_fila (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .dado_escrita(mov_codigo),
    .dado_leitura(dado_fila),
    .cheia       (fila_cheia),
    .vazia       (fila_vazia)
  );

  assign wd_expirou = (wd == WD_LIMITE);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    estado_prox   = estado;
    iniciar_garra = 1'b0;
    iniciar_servo = 1'b0;
    pop           = 1'b0;
    db_estado     = estado;
    case (estado)
      INICIAL:      if (!fila_vazia) estado_prox = CARREGA;
      CARREGA: begin
        pop         = 1'b1;
        estado_prox = FECHA_GARRA;
      end
      FECHA_GARRA: begin
        iniciar_garra = 1'b1;
        estado_prox   = ESPERA_FECHA;
      end
      ESPERA_FECHA: begin
        if (pronto_garra)    estado_prox = GIRA;
        else if (wd_expirou) estado_prox = ERRO;
      end
      GIRA: begin
        iniciar_servo = 1'b1;
        estado_prox   = ESPERA_GIRO;
      end
      ESPERA_GIRO: begin
        if (pronto_servo)    estado_prox = CONTA_QUARTO;
        else if (wd_expirou) estado_prox = ERRO;
      end
      // The decremented count is zero exactly when the current count is one.
      CONTA_QUARTO: estado_prox = (quartos == 2'd1) ? ABRE_GARRA : GIRA;
      ABRE_GARRA: begin
        iniciar_garra = 1'b1;
        estado_prox   = ESPERA_ABRE;
      end
      ESPERA_ABRE: begin
        if (pronto_garra)    estado_prox = INICIAL;
        else if (wd_expirou) estado_prox = ERRO;
      end
      ERRO:         estado_prox = ERRO;
      default: begin
        db_estado   = DB_ILEGAL;
        estado_prox = INICIAL;
      end
    endcase
  end

  assign ocupado = (estado != INICIAL);
  assign erro    = (estado == ERRO);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado  <= INICIAL;
      quartos <= '0;
      sentido <= 1'b0;
      fecha   <= GARRA_ABRE;
      wd      <= '0;
    end else begin
      estado <= estado_prox;
      if (estado == CARREGA) begin
        sentido <= dado_fila[BIT_SENTIDO];
        quartos <= dado_fila[QUARTOS_MSB:QUARTOS_LSB];
      end else if (estado == CONTA_QUARTO) begin
        quartos <= quartos - 2'd1;
      end
      // fecha is loaded as the pulse state is entered so it is valid with it.
      if (estado_prox == FECHA_GARRA)     fecha <= GARRA_FECHA;
      else if (estado_prox == ABRE_GARRA) fecha <= GARRA_ABRE;
      if (em_espera(estado)) wd <= wd + 1'b1;
      else                   wd <= '0;
    end
  end

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Directed bench for sequenciador_movimentos: auto-responding servo models,
// pulse logging and per-scenario checks against hand-computed values.
module tb_sequenciador_movimentos;

  localparam int PROF = 4;
  localparam int TO   = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mov_valido = 1'b0;
  logic [2:0] mov_codigo = 3'b000;
  logic       mov_pronto;
  logic       iniciar_servo;
  logic       sentido;
  logic       pronto_servo;
  logic       iniciar_garra;
  logic       fecha;
  logic       pronto_garra;
  logic       ocupado;
  logic       fila_vazia;
  logic       erro;
  logic [3:0] db_estado;

  logic man_garra  = 1'b0;
  logic man_servo  = 1'b0;
  logic resp_garra = 1'b0;
  logic resp_servo = 1'b0;
  bit   auto_garra = 1'b0;
  bit   auto_servo = 1'b0;
  int   cd_garra = 0;
  int   cd_servo = 0;

  logic [63:0] hist_garra = '0;
  logic [63:0] hist_servo = '0;
  int          n_garra = 0;
  int          n_servo = 0;

  int checks = 0;
  int errors = 0;

  assign pronto_garra = resp_garra | man_garra;
  assign pronto_servo = resp_servo | man_servo;

  always #5 clock = ~clock;

  sequenciador_movimentos #(
    .PROFUNDIDADE  (PROF),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mov_valido   (mov_valido),
    .mov_codigo   (mov_codigo),
    .mov_pronto   (mov_pronto),
    .iniciar_servo(iniciar_servo),
    .sentido      (sentido),
    .pronto_servo (pronto_servo),
    .iniciar_garra(iniciar_garra),
    .fecha        (fecha),
    .pronto_garra (pronto_garra),
    .ocupado      (ocupado),
    .fila_vazia   (fila_vazia),
    .erro         (erro),
    .db_estado    (db_estado)
  );

  // Servo unit models answer 5 cycles after each iniciar; every pulse is logged.
  always @(negedge clock) begin
    resp_garra = 1'b0;
    resp_servo = 1'b0;
    if (reset) begin
      cd_garra = 0;
      cd_servo = 0;
    end else begin
      if (cd_garra > 0) begin
        cd_garra--;
        if (cd_garra == 0) resp_garra = 1'b1;
      end
      if (cd_servo > 0) begin
        cd_servo--;
        if (cd_servo == 0) resp_servo = 1'b1;
      end
      if (iniciar_garra) begin
        if (n_garra < 64) hist_garra[n_garra] = fecha;
        n_garra++;
        if (auto_garra) cd_garra = 5;
      end
      if (iniciar_servo) begin
        if (n_servo < 64) hist_servo[n_servo] = sentido;
        n_servo++;
        if (auto_servo) cd_servo = 5;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic envia(input logic [2:0] c, input logic aceito, input string nome);
    mov_valido = 1'b1;
    mov_codigo = c;
    checks++;
    if (mov_pronto !== aceito) begin
      errors++;
      $display("FAIL %s: mov_pronto=%b expected %b", nome, mov_pronto, aceito);
    end
    tick();
    mov_valido = 1'b0;
    mov_codigo = 3'b000;
  endtask

  task automatic espera_estado(input logic [3:0] alvo, input int limite, input string nome);
    int n = 0;
    while (db_estado !== alvo && n < limite) begin
      tick();
      n++;
    end
    checks++;
    if (db_estado !== alvo) begin
      errors++;
      $display("FAIL %s: db_estado=%b expected %b within %0d cycles", nome, db_estado, alvo, limite);
    end
  endtask

  task automatic espera_ocioso(input int limite, input string nome);
    int n = 0;
    while ((ocupado !== 1'b0 || fila_vazia !== 1'b1) && n < limite) begin
      tick();
      n++;
    end
    checks++;
    if (ocupado !== 1'b0 || fila_vazia !== 1'b1) begin
      errors++;
      $display("FAIL %s: ocupado=%b fila_vazia=%b expected 0/1 within %0d cycles",
               nome, ocupado, fila_vazia, limite);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({mov_pronto, fila_vazia} !== 2'b11) begin
      errors++;
      $display("FAIL reset_handshake: mov_pronto,fila_vazia=%b expected 11", {mov_pronto, fila_vazia});
    end
    checks++;
    if (db_estado !== 4'b0000) begin
      errors++;
      $display("FAIL reset_estado: db_estado=%b expected 0000", db_estado);
    end
    checks++;
    if ({iniciar_servo, iniciar_garra, sentido, fecha, ocupado, erro} !== 6'b0) begin
      errors++;
      $display("FAIL reset_saidas: servo,garra,sentido,fecha,ocupado,erro=%b expected 000000",
               {iniciar_servo, iniciar_garra, sentido, fecha, ocupado, erro});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_movimento_simples();
    int g0 = n_garra;
    int s0 = n_servo;
    logic [63:0] hg;
    logic [63:0] hs;
    auto_garra = 1'b1;
    auto_servo = 1'b1;
    envia(3'b010, 1'b1, "simples_push");
    checks++;
    if ({fila_vazia, db_estado} !== 5'b0_0000) begin
      errors++;
      $display("FAIL simples_apos_push: fila_vazia,db_estado=%b expected 0_0000", {fila_vazia, db_estado});
    end
    tick();
    checks++;
    if (db_estado !== 4'b0001) begin
      errors++;
      $display("FAIL simples_carrega: db_estado=%b expected 0001", db_estado);
    end
    tick();
    checks++;
    if ({db_estado, iniciar_garra, fecha} !== 6'b0010_1_1) begin
      errors++;
      $display("FAIL simples_fecha: db_estado,iniciar_garra,fecha=%b expected 0010_1_1",
               {db_estado, iniciar_garra, fecha});
    end
    espera_ocioso(200, "simples_fim");
    hg = hist_garra >> g0;
    hs = hist_servo >> s0;
    checks++;
    if ((n_garra - g0) != 2 || hg[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL simples_garra: pulses=%0d fecha_seq=%b expected 2 pulses seq 01 (close then open)",
               n_garra - g0, hg[1:0]);
    end
    checks++;
    if ((n_servo - s0) != 2 || hs[1:0] !== 2'b00) begin
      errors++;
      $display("FAIL simples_servo: pulses=%0d sentido_seq=%b expected 2 pulses seq 00",
               n_servo - s0, hs[1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int g0 = n_garra;
    int s0 = n_servo;
    logic [63:0] hg;
    logic [63:0] hs;
    auto_garra = 1'b0;
    auto_servo = 1'b1;
    envia(3'b001, 1'b1, "b2b_primeiro");
    espera_estado(4'b0011, 20, "b2b_parado_fecha");
    envia(3'b111, 1'b1, "b2b_push1");
    envia(3'b001, 1'b1, "b2b_push2");
    envia(3'b101, 1'b1, "b2b_push3");
    envia(3'b011, 1'b1, "b2b_push4");
    checks++;
    if ({mov_pronto, fila_vazia} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_cheia: mov_pronto,fila_vazia=%b expected 00", {mov_pronto, fila_vazia});
    end
    envia(3'b010, 1'b0, "b2b_push5_recusado");
    man_garra = 1'b1;
    tick();
    man_garra = 1'b0;
    auto_garra = 1'b1;
    checks++;
    if (db_estado !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_libera: db_estado=%b expected 0100", db_estado);
    end
    espera_ocioso(600, "b2b_fim");
    hg = hist_garra >> g0;
    hs = hist_servo >> s0;
    checks++;
    if ((n_garra - g0) != 10 || hg[9:0] !== 10'h155) begin
      errors++;
      $display("FAIL b2b_garra: pulses=%0d fecha_seq=%h expected 10 pulses seq 155",
               n_garra - g0, hg[9:0]);
    end
    checks++;
    if ((n_servo - s0) != 9 || hs[8:0] !== 9'h02E) begin
      errors++;
      $display("FAIL b2b_servo: pulses=%0d sentido_seq=%h expected 9 pulses seq 02e",
               n_servo - s0, hs[8:0]);
    end
  endtask

  task automatic test_movimento_nulo();
    int g0 = n_garra;
    int s0 = n_servo;
    envia(3'b100, 1'b1, "nulo_handshake");
    checks++;
    if (fila_vazia !== 1'b1) begin
      errors++;
      $display("FAIL nulo_fila: fila_vazia=%b expected 1", fila_vazia);
    end
    repeat (10) tick();
    checks++;
    if ((n_garra - g0) != 0 || (n_servo - s0) != 0 || {ocupado, db_estado} !== 5'b0) begin
      errors++;
      $display("FAIL nulo_sem_pulsos: garra=%0d servo=%0d ocupado,db_estado=%b expected 0 0 00000",
               n_garra - g0, n_servo - s0, {ocupado, db_estado});
    end
  endtask

  task automatic test_ignora_pronto();
    auto_garra = 1'b0;
    auto_servo = 1'b0;
    envia(3'b001, 1'b1, "ignora_push");
    espera_estado(4'b0011, 20, "ignora_espera_fecha");
    man_servo = 1'b1;
    tick();
    man_servo = 1'b0;
    tick();
    checks++;
    if (db_estado !== 4'b0011) begin
      errors++;
      $display("FAIL ignora_pronto_servo: db_estado=%b expected 0011", db_estado);
    end
    man_garra = 1'b1;
    tick();
    man_garra = 1'b0;
    checks++;
    if ({db_estado, iniciar_servo} !== 5'b0100_1) begin
      errors++;
      $display("FAIL ignora_gira: db_estado,iniciar_servo=%b expected 0100_1", {db_estado, iniciar_servo});
    end
  endtask

  // Continues from the gira cycle left by test_ignora_pronto; no servo answers.
  task automatic test_timeout();
    repeat (20) tick();
    checks++;
    if ({db_estado, erro} !== 5'b0101_0) begin
      errors++;
      $display("FAIL timeout_antes: db_estado,erro=%b expected 0101_0", {db_estado, erro});
    end
    tick();
    checks++;
    if ({db_estado, erro, mov_pronto} !== 6'b1111_1_0) begin
      errors++;
      $display("FAIL timeout_erro: db_estado,erro,mov_pronto=%b expected 1111_1_0",
               {db_estado, erro, mov_pronto});
    end
    man_servo = 1'b1;
    tick();
    man_servo = 1'b0;
    envia(3'b001, 1'b0, "timeout_recusa");
    repeat (5) tick();
    checks++;
    if ({db_estado, erro, iniciar_garra, iniciar_servo} !== 7'b1111_1_00) begin
      errors++;
      $display("FAIL timeout_pegajoso: db_estado,erro,garra,servo=%b expected 1111_1_00",
               {db_estado, erro, iniciar_garra, iniciar_servo});
    end
  endtask

  task automatic test_reset_meio();
    int g0;
    int s0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({erro, db_estado} !== 5'b0) begin
      errors++;
      $display("FAIL reset_limpa_erro: erro,db_estado=%b expected 00000", {erro, db_estado});
    end
    auto_garra = 1'b1;
    auto_servo = 1'b1;
    envia(3'b011, 1'b1, "meio_push1");
    envia(3'b010, 1'b1, "meio_push2");
    envia(3'b001, 1'b1, "meio_push3");
    espera_estado(4'b0101, 40, "meio_espera_giro");
    checks++;
    if (fila_vazia !== 1'b0) begin
      errors++;
      $display("FAIL meio_fila_ocupada: fila_vazia=%b expected 0", fila_vazia);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({db_estado, fila_vazia, ocupado} !== 6'b0000_1_0) begin
      errors++;
      $display("FAIL meio_reset: db_estado,fila_vazia,ocupado=%b expected 0000_1_0",
               {db_estado, fila_vazia, ocupado});
    end
    reset = 1'b0;
    g0 = n_garra;
    s0 = n_servo;
    repeat (20) tick();
    checks++;
    if ((n_garra - g0) != 0 || (n_servo - s0) != 0 || {db_estado, fila_vazia} !== 5'b0000_1) begin
      errors++;
      $display("FAIL meio_sem_pulsos: garra=%0d servo=%0d db_estado,fila_vazia=%b expected 0 0 0000_1",
               n_garra - g0, n_servo - s0, {db_estado, fila_vazia});
    end
  endtask

  initial begin
    test_reset();
    test_movimento_simples();
    test_back_to_back();
    test_movimento_nulo();
    test_ignora_pronto();
    test_timeout();
    test_reset_meio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
